// File: rtl/shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe
//
// Purpose:
//   Pipelined Rijndael ShiftRows / InvShiftRows stage for block widths of
//   NB = 4, 6 or 8 columns. The mode is chosen per beat. Each beat is held in
//   a 2-deep registered elastic pipeline together with a sideband tag.
//   The stage sits between SubBytes and MixColumns in the encrypt round, and
//   between their inverses in the decrypt round.
//
// Parameters:
//   NB     - number of state columns (4, 6 or 8)
//   TAG_W  - width of the sideband tag carried with each beat (>= 1)
//
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   in_valid/in_ready - upstream handshake
//   in_data           - state; byte k = in_data[8k+7:8k], row k%4, column k/4
//   in_inv            - 0 = ShiftRows, 1 = InvShiftRows, applies to this beat
//   in_tag            - sideband tag, passed through unchanged
//   out_valid/out_ready - downstream handshake
//   out_data, out_tag - permuted state and its tag, driven straight from
//                       the output register
//   busy              - at least one beat is held in the pipeline
// ---------------------------------------------------------------------------
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int W = 32 * NB;

  // Reject unsupported geometries at elaboration time.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : gBadNb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : gBadTag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  // Rijndael row offsets: 0,1,2,3 for NB=4/6; 0,1,3,4 for NB=8.
  function automatic int rowShift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  // Both permutations are pure wiring. The source column for every output
  // byte is resolved at elaboration, so the mod-NB wrap costs no logic.
  logic [W-1:0] fwdPerm;
  logic [W-1:0] invPerm;
  logic [W-1:0] permData;

  for (genvar c = 0; c < NB; c++) begin : gCol
    for (genvar r = 0; r < 4; r++) begin : gRow
      localparam int S       = rowShift(r);
      localparam int FWD_SRC = (c + S) % NB;
      localparam int INV_SRC = (c - S + NB) % NB;
      assign fwdPerm[8*(r+4*c) +: 8] = in_data[8*(r+4*FWD_SRC) +: 8];
      assign invPerm[8*(r+4*c) +: 8] = in_data[8*(r+4*INV_SRC) +: 8];
    end
  end

  assign permData = in_inv ? invPerm : fwdPerm;

  // Pipeline state: stage A holds freshly permuted beats. Stage B is the
  // output register.
  logic             aValid_q, aValid_d;
  logic [W-1:0]     aData_q,  aData_d;
  logic [TAG_W-1:0] aTag_q,   aTag_d;
  logic             bValid_q, bValid_d;
  logic [W-1:0]     bData_q,  bData_d;
  logic [TAG_W-1:0] bTag_q,   bTag_d;

  logic accept;
  logic aMove;
  logic bDrain;

  // Handshake and next-state logic. B drains on a downstream accept. A moves
  // into B whenever B is empty or draining. A new beat can enter whenever A
  // is empty or will move on this edge. This is why in_ready depends only on
  // out_ready and the stage flags, and never on in_valid.
  always_comb begin
    aValid_d = aValid_q;
    aData_d  = aData_q;
    aTag_d   = aTag_q;
    bValid_d = bValid_q;
    bData_d  = bData_q;
    bTag_d   = bTag_q;

    in_ready = !aValid_q || !bValid_q || out_ready;
    accept   = in_valid && in_ready;
    aMove    = aValid_q && (!bValid_q || out_ready);
    bDrain   = bValid_q && out_ready;

    if (aMove) begin
      bValid_d = 1'b1;
      bData_d  = aData_q;
      bTag_d   = aTag_q;
      aValid_d = 1'b0;
    end else if (bDrain) begin
      bValid_d = 1'b0;
    end

    if (accept) begin
      aValid_d = 1'b1;
      aData_d  = permData;
      aTag_d   = in_tag;
    end
  end

  // State registers. Reset discards any beats in flight and zeroes the
  // payload, so out_data/out_tag read 0 while the pipeline is empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aValid_q <= 1'b0;
      aData_q  <= '0;
      aTag_q   <= '0;
      bValid_q <= 1'b0;
      bData_q  <= '0;
      bTag_q   <= '0;
    end else begin
      aValid_q <= aValid_d;
      aData_q  <= aData_d;
      aTag_q   <= aTag_d;
      bValid_q <= bValid_d;
      bData_q  <= bData_d;
      bTag_q   <= bTag_d;
    end
  end

  assign out_valid = bValid_q;
  assign out_data  = bData_q;
  assign out_tag   = bTag_q;
  assign busy      = aValid_q || bValid_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_rows_pipe
//
// Purpose:
//   Self-checking bench for shift_rows_pipe. Three instances (NB = 4, 6, 8)
//   share handshake and data stimulus. A driver pushes expected beats into
//   per-instance queues at acceptance, and a monitor pops and compares them
//   whenever an instance hands a beat downstream. Expected values come from
//   a row-rotation reference model or from hand-derived constants.
// ---------------------------------------------------------------------------
module tb_shift_rows_pipe;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   tag;
  } beat_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         inValid = 1'b0;
  logic [255:0] inData = '0;
  logic         inInv = 1'b0;
  logic [3:0]   inTag = '0;
  logic         outReady = 1'b0;

  logic         inReady4, inReady6, inReady8;
  logic         outValid4, outValid6, outValid8;
  logic [127:0] outData4;
  logic [191:0] outData6;
  logic [255:0] outData8;
  logic [3:0]   outTag4, outTag6, outTag8;
  logic         busy4, busy6, busy8;

  beat_t q4[$];
  beat_t q6[$];
  beat_t q8[$];

  int nCompared = 0;
  int nMismatched = 0;
  int issued[3] = '{0, 0, 0};
  int received[3] = '{0, 0, 0};
  int readyMode = 1;
  bit stalled[3] = '{0, 0, 0};
  logic [255:0] heldData[3];
  logic [3:0]   heldTag[3];

  always #5 clock = ~clock;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut4 (
    .clk(clock), .rst(reset), .in_valid(inValid), .in_ready(inReady4),
    .in_data(inData[127:0]), .in_inv(inInv), .in_tag(inTag),
    .out_valid(outValid4), .out_ready(outReady), .out_data(outData4),
    .out_tag(outTag4), .busy(busy4));

  shift_rows_pipe #(.NB(6), .TAG_W(4)) dut6 (
    .clk(clock), .rst(reset), .in_valid(inValid), .in_ready(inReady6),
    .in_data(inData[191:0]), .in_inv(inInv), .in_tag(inTag),
    .out_valid(outValid6), .out_ready(outReady), .out_data(outData6),
    .out_tag(outTag6), .busy(busy6));

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clock), .rst(reset), .in_valid(inValid), .in_ready(inReady8),
    .in_data(inData), .in_inv(inInv), .in_tag(inTag),
    .out_valid(outValid8), .out_ready(outReady), .out_data(outData8),
    .out_tag(outTag8), .busy(busy8));

  // Per-instance views so the checking code can loop over the three DUTs.
  function automatic logic rdyOf(input int i);
    case (i)
      0: return inReady4;
      1: return inReady6;
      default: return inReady8;
    endcase
  endfunction

  function automatic logic vldOf(input int i);
    case (i)
      0: return outValid4;
      1: return outValid6;
      default: return outValid8;
    endcase
  endfunction

  function automatic logic [255:0] datOf(input int i);
    case (i)
      0: return {128'b0, outData4};
      1: return {64'b0, outData6};
      default: return outData8;
    endcase
  endfunction

  function automatic logic [3:0] tagOf(input int i);
    case (i)
      0: return outTag4;
      1: return outTag6;
      default: return outTag8;
    endcase
  endfunction

  function automatic logic bsyOf(input int i);
    case (i)
      0: return busy4;
      1: return busy6;
      default: return busy8;
    endcase
  endfunction

  function automatic int nbOf(input int i);
    case (i)
      0: return 4;
      1: return 6;
      default: return 8;
    endcase
  endfunction

  // Reference model: unpack into a 4 x nb byte matrix and rotate each row
  // left one column at a time. Inverse is a left rotation by nb - s.
  function automatic logic [255:0] refShift(input logic [255:0] d, input int nb, input bit inv);
    logic [7:0] st[4][8];
    logic [7:0] tmp;
    int offs[4];
    int amt;
    logic [255:0] res;
    res = '0;
    offs[0] = 0;
    offs[1] = 1;
    offs[2] = (nb == 8) ? 3 : 2;
    offs[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = (c < nb) ? d[8*(4*c+r) +: 8] : 8'h00;
    for (int r = 0; r < 4; r++) begin
      amt = inv ? (nb - offs[r]) % nb : offs[r];
      repeat (amt) begin
        tmp = st[r][0];
        for (int c = 0; c < nb - 1; c++) st[r][c] = st[r][c+1];
        st[r][nb-1] = tmp;
      end
    end
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        res[8*(4*c+r) +: 8] = st[r][c];
    return res;
  endfunction

  function automatic logic [255:0] maskTo(input logic [255:0] d, input int nb);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < 32 * nb; k++) m[k] = 1'b1;
    return d & m;
  endfunction

  function automatic logic pickReady();
    case (readyMode)
      0: return 1'b0;
      1: return 1'b1;
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic checkEq(input string name, input logic [255:0] act, input logic [255:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int i, input logic [255:0] d, input logic [3:0] t);
    beat_t b;
    b.data = d;
    b.tag  = t;
    case (i)
      0: q4.push_back(b);
      1: q6.push_back(b);
      default: q8.push_back(b);
    endcase
    issued[i]++;
  endtask

  // Offers one beat until instance NB=4 accepts it. The expected result is
  // queued for every instance that accepts on the same edge.
  task automatic applyStimulus(input logic [255:0] d, input bit inv, input logic [3:0] tag,
                               input logic [255:0] e4, input logic [255:0] e6,
                               input logic [255:0] e8, output int cycles);
    bit done;
    done = 0;
    cycles = 0;
    while (!done && cycles < 50) begin
      @(negedge clock);
      inValid  = 1'b1;
      inData   = d;
      inInv    = inv;
      inTag    = tag;
      outReady = pickReady();
      #1;
      cycles++;
      if (inReady4) begin pushExp(0, e4, tag); done = 1; end
      if (inReady6) pushExp(1, e6, tag);
      if (inReady8) pushExp(2, e8, tag);
    end
    if (!done) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL accept timeout: got in_ready 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic sendModel(input logic [255:0] d, input bit inv, input logic [3:0] tag,
                           output int cycles);
    applyStimulus(d, inv, tag, refShift(d, 4, inv), refShift(d, 6, inv),
                  refShift(d, 8, inv), cycles);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clock);
      inValid  = 1'b0;
      outReady = pickReady();
      #1;
    end
  endtask

  task automatic checkOutput(input int i);
    beat_t e;
    bit have;
    if (stalled[i]) begin
      checkEq($sformatf("stall valid nb%0d", nbOf(i)), {255'b0, vldOf(i)}, 256'd1);
      checkEq($sformatf("stall data nb%0d", nbOf(i)), datOf(i), heldData[i]);
      checkEq($sformatf("stall tag nb%0d", nbOf(i)), {252'b0, tagOf(i)}, {252'b0, heldTag[i]});
    end
    if (vldOf(i) && outReady) begin
      have = 0;
      case (i)
        0: if (q4.size() > 0) begin e = q4.pop_front(); have = 1; end
        1: if (q6.size() > 0) begin e = q6.pop_front(); have = 1; end
        default: if (q8.size() > 0) begin e = q8.pop_front(); have = 1; end
      endcase
      received[i]++;
      if (!have) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected beat nb%0d: got %h expected none", nbOf(i), datOf(i));
      end else begin
        checkEq($sformatf("data nb%0d", nbOf(i)), datOf(i), maskTo(e.data, nbOf(i)));
        checkEq($sformatf("tag nb%0d", nbOf(i)), {252'b0, tagOf(i)}, {252'b0, e.tag});
      end
    end
    stalled[i]  = vldOf(i) && !outReady;
    heldData[i] = datOf(i);
    heldTag[i]  = tagOf(i);
  endtask

  // Monitor: runs after the driver has settled the cycle's inputs and
  // evaluates the handshake that completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        for (int i = 0; i < 3; i++) stalled[i] = 0;
      end else begin
        for (int i = 0; i < 3; i++) checkOutput(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic [255:0] seq;
    logic [255:0] e6;
    logic [255:0] e8;
    logic [255:0] rnd;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkEq($sformatf("reset out_valid nb%0d", nbOf(i)), {255'b0, vldOf(i)}, 256'd0);
      checkEq($sformatf("reset busy nb%0d", nbOf(i)), {255'b0, bsyOf(i)}, 256'd0);
      checkEq($sformatf("reset out_data nb%0d", nbOf(i)), datOf(i), 256'd0);
    end
    reset = 1'b0;
    #1;
    checkEq("in_ready after reset", {255'b0, inReady4}, 256'd1);

    // Forward NB=4 directed vector, with latency observation.
    readyMode = 1;
    applyStimulus({128'b0, 128'hffeeddccbbaa99887766554433221100}, 1'b0, 4'h1,
                  {128'b0, 128'hbb6611cc7722dd8833ee9944ffaa5500},
                  refShift({128'b0, 128'hffeeddccbbaa99887766554433221100}, 6, 1'b0),
                  refShift({128'b0, 128'hffeeddccbbaa99887766554433221100}, 8, 1'b0), cyc);
    idleCycles(1);
    checkEq("latency stage A only", {255'b0, outValid4}, 256'd0);
    checkEq("latency busy", {255'b0, busy4}, 256'd1);
    idleCycles(1);
    checkEq("latency out_valid", {255'b0, outValid4}, 256'd1);
    idleCycles(2);

    // Inverse round-trip on NB=4.
    applyStimulus({128'b0, 128'hbb6611cc7722dd8833ee9944ffaa5500}, 1'b1, 4'h2,
                  {128'b0, 128'hffeeddccbbaa99887766554433221100},
                  refShift({128'b0, 128'hbb6611cc7722dd8833ee9944ffaa5500}, 6, 1'b1),
                  refShift({128'b0, 128'hbb6611cc7722dd8833ee9944ffaa5500}, 8, 1'b1), cyc);
    idleCycles(3);

    // Alternating modes, back-to-back, tags 0..7 at one beat per cycle.
    for (int t = 0; t < 8; t++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sendModel(rnd, t[0], t[3:0], cyc);
      checkEq("back-to-back accept cycles", cyc, 1);
    end
    idleCycles(3);

    // Byte k = k: NB=8 offsets 0,1,3,4 and the NB=6 column wrap.
    for (int k = 0; k < 32; k++) seq[8*k +: 8] = k[7:0];
    e6 = refShift(seq, 6, 1'b0);
    e6[31:0]    = 32'h0f0a0500;
    e6[191:160] = 32'h0b060114;
    e8 = refShift(seq, 8, 1'b0);
    e8[31:0]    = 32'h130e0500;
    applyStimulus(seq, 1'b0, 4'h3, refShift(seq, 4, 1'b0), e6, e8, cyc);
    e8 = refShift(seq, 8, 1'b0);
    applyStimulus(e8, 1'b1, 4'h4, refShift(e8, 4, 1'b1), refShift(e8, 6, 1'b1), seq, cyc);
    idleCycles(3);

    // Backpressure: two beats fill the pipe, a third is refused.
    readyMode = 0;
    sendModel({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 4'h8, cyc);
    sendModel({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 4'h9, cyc);
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      inValid  = 1'b1;
      inData   = rnd;
      inInv    = 1'b0;
      inTag    = 4'ha;
      outReady = 1'b0;
      #1;
      checkEq("full in_ready", {255'b0, inReady4}, 256'd0);
      checkEq("full busy", {255'b0, busy4}, 256'd1);
    end
    readyMode = 1;
    sendModel(rnd, 1'b0, 4'ha, cyc);
    checkEq("release accept cycles", cyc, 1);
    idleCycles(4);

    // Randomized traffic with random backpressure and gaps.
    readyMode = 2;
    for (int n = 0; n < 150; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      sendModel(rnd, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), cyc);
      if ($urandom_range(0, 4) == 0) idleCycles($urandom_range(1, 3));
    end
    readyMode = 1;
    idleCycles(4);

    // Asynchronous reset with both stages full.
    readyMode = 0;
    sendModel({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 4'hb, cyc);
    sendModel({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 4'hc, cyc);
    @(negedge clock);
    inValid = 1'b0;
    #1;
    checkEq("pre-reset in_ready", {255'b0, inReady4}, 256'd0);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkEq($sformatf("async reset out_valid nb%0d", nbOf(i)), {255'b0, vldOf(i)}, 256'd0);
      checkEq($sformatf("async reset busy nb%0d", nbOf(i)), {255'b0, bsyOf(i)}, 256'd0);
      checkEq($sformatf("async reset out_data nb%0d", nbOf(i)), datOf(i), 256'd0);
      checkEq($sformatf("async reset out_tag nb%0d", nbOf(i)), {252'b0, tagOf(i)}, 256'd0);
      stalled[i] = 0;
    end
    issued[0] -= q4.size();
    issued[1] -= q6.size();
    issued[2] -= q8.size();
    q4.delete();
    q6.delete();
    q8.delete();
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkEq("post-reset in_ready", {255'b0, inReady4}, 256'd1);
    readyMode = 1;
    sendModel({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1, 4'hd, cyc);

    // Drain and confirm nothing was lost or duplicated.
    for (int k = 0; k < 300 && (q4.size() + q6.size() + q8.size()) != 0; k++) idleCycles(1);
    idleCycles(2);
    for (int i = 0; i < 3; i++)
      checkEq($sformatf("beat count nb%0d", nbOf(i)), received[i], issued[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined AES/Rijndael ShiftRows stage with per-beat forward/inverse mode and a valid/ready handshake on both sides. It generalises the combinational 128-bit shiftRows_1 to Rijndael block widths of Nb = 4, 6 or 8 columns. It adds InvShiftRows and a 2-deep registered elastic pipeline with a sideband tag. It sits between SubBytes and MixColumns in the round datapath, and between their inverses in the decrypt datapath.

Parameters:
NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error.
TAG_W, 4, width of the sideband tag carried alongside each beat (round number or stream ID); minimum 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-high.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  32*NB  state; byte k = in_data[8k+7:8k], row r = k%4, column c = k/4 (FIPS-197 column-major).
in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the beat.
in_tag  input  TAG_W  sideband, passed through unchanged.
out_valid  output  1  output beat valid.
out_ready  input  1  downstream accepts the beat.
out_data  output  32*NB  permuted state, same byte layout as in_data.
out_tag  output  TAG_W  tag of the beat on out_data.
busy  output  1  at least one beat held in the pipeline.

Behaviour:
- Row offsets s(r): NB=4 or 6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
- Forward: out[r][c] = in[r][(c + s(r)) mod NB].
- Inverse: out[r][c] = in[r][(c - s(r) + NB) mod NB].
- Modulo is over NB, not a power of two. NB=6 must wrap correctly.
- Pure byte permutation; no arithmetic. in_inv affects only its own beat, so mode may change on every beat.
- Pipeline has two register stages:
  - Stage A (a_valid, a_data, a_tag) captures the permuted in_data when in_valid & in_ready.
  - Stage B (b_valid, b_data, b_tag) drives out_valid, out_data and out_tag directly; there is no combinational path from in_data to out_data.
- Transfer rules:
  - B drains when b_valid & out_ready.
  - A moves to B when a_valid & (!b_valid | out_ready).
  - in_ready = !a_valid | !b_valid | out_ready. This is combinational on out_ready; there is no path from in_valid to in_ready.
- Latency: a beat accepted on edge t is presented on out_valid after edge t+1, with no stall. Throughput is 1 beat/cycle when out_ready is held high.
- Simultaneous events:
  - Accept, A->B move and B drain may all occur on the same edge.
  - Beats are never dropped, duplicated or reordered.
- Stall: with out_ready=0, B holds and A fills. in_ready then falls only after both stages are valid, giving a capacity of 2 beats.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_tag must not change.
- busy = a_valid | b_valid.
- Reset: asserting rst at any time, including mid-stream, immediately clears a_valid and b_valid. Data and tag registers are cleared to 0, so out_valid=0, out_data=0, out_tag=0 and busy=0. in_ready=1 in the first cycle after rst deasserts. Beats in flight are discarded.

Test Plan:
- Forward, NB=4: in_data bytes 0..15 = 00,11,...,ff; in_inv=0; out_ready=1 -> out_valid rises 2 edges after accept. out bytes 0..15 = 00 55 aa ff 44 99 ee 33 88 dd 22 77 cc 11 66 bb.
- Inverse round-trip, NB=4: feed the previous output with in_inv=1 -> out bytes = 00 11 22 ... ff. Then alternate in_inv on 8 back-to-back beats -> each beat matches its own mode at 1 beat/cycle, and tags 0..7 emerge in order.
- Backpressure, NB=4: out_ready=0, push 3 beats -> 2 accepted, in_ready=0 on the third, out_data stable. Raise out_ready -> all 3 delivered in order, none lost.
- Forward, NB=8 with offsets 0,1,3,4: byte k = k -> out bytes 0..3 = 00 05 0e 13. Inverse of that output restores byte k = k.
- Forward, NB=6: byte k = k -> out bytes 0..3 = 00 05 0a 0f. Column 5 wraps: out bytes 20..23 = 14 01 06 0b.
- Reset mid-stream: assert rst asynchronously with both stages full -> out_valid=0, busy=0, out_data=0 with no clock edge. After release, one new beat passes with the correct result.
